// File: rtl/pipeline_hazard_ctrl.sv
// ============================================================================
// Module  : pipeline_hazard_ctrl
// Brief   : Stall/flush sequencer for the 5-stage LC-3b pipeline.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module pipeline_hazard_ctrl #(
  parameter int CNT_W   = 16,
  parameter int TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [2:0]       id_sr1,
  input  logic [2:0]       id_sr2,
  input  logic             id_sr1_used,
  input  logic             id_sr2_used,
  input  logic [2:0]       idex_dest,
  input  logic             idex_mem_read,
  input  logic             imem_req,
  input  logic             imem_resp,
  input  logic             dmem_req,
  input  logic             dmem_resp,
  input  logic             mem_br_taken,
  output logic             load_pc,
  output logic             load_if_id,
  output logic             load_id_ex,
  output logic             load_ex_mem,
  output logic             load_mem_wb,
  output logic             flush_if_id,
  output logic             flush_id_ex,
  output logic             flush_ex_mem,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] stall_cycles,
  output logic             mem_timeout
);

  typedef enum logic [1:0] {
    ST_RUN   = 2'b00,
    ST_DWAIT = 2'b01,
    ST_IWAIT = 2'b10
  } state_t;

  localparam logic [7:0]       C_TIMEOUT = 8'(TIMEOUT);
  localparam logic [CNT_W-1:0] C_CNT_ONE = CNT_W'(1);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [7:0]       r_wait_cnt;
  logic [7:0]       w_wait_nxt;
  logic [CNT_W-1:0] r_stall_cycles;
  logic             r_mem_timeout;

  logic w_dstall;
  logic w_istall;
  logic w_lu;
  logic w_stall_cycle;

  assign w_dstall = dmem_req & ~dmem_resp;
  assign w_istall = imem_req & ~imem_resp;
  assign w_lu     = idex_mem_read &
                    ((id_sr1_used & (id_sr1 == idex_dest)) |
                     (id_sr2_used & (id_sr2 == idex_dest)));

  // Priority: freeze (D then I) > taken branch > load-use bubble > run.
  always_comb begin
    load_pc       = 1'b0;
    load_if_id    = 1'b0;
    load_id_ex    = 1'b0;
    load_ex_mem   = 1'b0;
    load_mem_wb   = 1'b0;
    flush_if_id   = 1'b0;
    flush_id_ex   = 1'b0;
    flush_ex_mem  = 1'b0;
    w_stall_cycle = 1'b0;
    if (reset_n) begin
      if (w_dstall || w_istall) begin
        w_stall_cycle = 1'b1;
      end else if (mem_br_taken) begin
        load_pc      = 1'b1;
        load_if_id   = 1'b1;
        load_id_ex   = 1'b1;
        load_ex_mem  = 1'b1;
        load_mem_wb  = 1'b1;
        flush_if_id  = 1'b1;
        flush_id_ex  = 1'b1;
        flush_ex_mem = 1'b1;
      end else if (w_lu) begin
        load_id_ex    = 1'b1;
        load_ex_mem   = 1'b1;
        load_mem_wb   = 1'b1;
        flush_id_ex   = 1'b1;
        w_stall_cycle = 1'b1;
      end else begin
        load_pc     = 1'b1;
        load_if_id  = 1'b1;
        load_id_ex  = 1'b1;
        load_ex_mem = 1'b1;
        load_mem_wb = 1'b1;
      end
    end
  end

  // Every state resolves the same way: a D-wait dominates an I-wait.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_RUN, ST_DWAIT, ST_IWAIT: begin
        if (w_dstall)      w_state_nxt = ST_DWAIT;
        else if (w_istall) w_state_nxt = ST_IWAIT;
        else               w_state_nxt = ST_RUN;
      end
      default: w_state_nxt = ST_RUN;
    endcase
  end

  always_comb begin
    w_wait_nxt = 8'd0;
    if ((w_state_nxt == r_state) && (r_state != ST_RUN)) begin
      w_wait_nxt = (r_wait_cnt == 8'hFF) ? r_wait_cnt : r_wait_cnt + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state        <= ST_RUN;
      r_wait_cnt     <= 8'd0;
      r_stall_cycles <= '0;
      r_mem_timeout  <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_wait_cnt <= w_wait_nxt;
      if (w_stall_cycle && (r_stall_cycles != '1)) begin
        r_stall_cycles <= r_stall_cycles + C_CNT_ONE;
      end
      // Flag rises together with the counter reaching the threshold.
      if ((w_wait_nxt == C_TIMEOUT) && (w_state_nxt != ST_RUN)) begin
        r_mem_timeout <= 1'b1;
      end
    end
  end

  assign state        = r_state;
  assign stall_cycles = r_stall_cycles;
  assign mem_timeout  = r_mem_timeout;

endmodule

`default_nettype wire

// File: tb/tb_pipeline_hazard_ctrl.sv
// ============================================================================
// Module  : tb_pipeline_hazard_ctrl
// Brief   : Directed vector table plus multi-cycle sequences for the sequencer.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_pipeline_hazard_ctrl;

  localparam int CNT_W   = 4;
  localparam int TIMEOUT = 8;

  logic clk = 1'b0;
  logic reset_n;
  logic [2:0] id_sr1, id_sr2, idex_dest;
  logic id_sr1_used, id_sr2_used, idex_mem_read;
  logic imem_req, imem_resp, dmem_req, dmem_resp, mem_br_taken;
  logic load_pc, load_if_id, load_id_ex, load_ex_mem, load_mem_wb;
  logic flush_if_id, flush_id_ex, flush_ex_mem;
  logic [1:0] state;
  logic [CNT_W-1:0] stall_cycles;
  logic mem_timeout;

  logic [4:0] w_ld;
  logic [2:0] w_fl;
  assign w_ld = {load_pc, load_if_id, load_id_ex, load_ex_mem, load_mem_wb};
  assign w_fl = {flush_if_id, flush_id_ex, flush_ex_mem};

  pipeline_hazard_ctrl #(.CNT_W(CNT_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset_n(reset_n),
    .id_sr1(id_sr1), .id_sr2(id_sr2),
    .id_sr1_used(id_sr1_used), .id_sr2_used(id_sr2_used),
    .idex_dest(idex_dest), .idex_mem_read(idex_mem_read),
    .imem_req(imem_req), .imem_resp(imem_resp),
    .dmem_req(dmem_req), .dmem_resp(dmem_resp),
    .mem_br_taken(mem_br_taken),
    .load_pc(load_pc), .load_if_id(load_if_id), .load_id_ex(load_id_ex),
    .load_ex_mem(load_ex_mem), .load_mem_wb(load_mem_wb),
    .flush_if_id(flush_if_id), .flush_id_ex(flush_id_ex),
    .flush_ex_mem(flush_ex_mem),
    .state(state), .stall_cycles(stall_cycles), .mem_timeout(mem_timeout)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] sr1;
    logic [2:0] sr2;
    logic       u1;
    logic       u2;
    logic [2:0] dest;
    logic       mr;
    logic       ireq;
    logic       iresp;
    logic       dreq;
    logic       dresp;
    logic       br;
    logic [4:0] ld;
    logic [2:0] fl;
    logic [1:0] st;
    logic       stl;
  } vec_t;

  vec_t vt[14];
  int   n_cmp = 0;
  int   n_err = 0;
  int   exp_cnt;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic idle();
    id_sr1 = 3'd0; id_sr2 = 3'd0; id_sr1_used = 1'b0; id_sr2_used = 1'b0;
    idex_dest = 3'd0; idex_mem_read = 1'b0;
    imem_req = 1'b0; imem_resp = 1'b0; dmem_req = 1'b0; dmem_resp = 1'b0;
    mem_br_taken = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    idle();
    reset_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  initial begin
    reset_n = 1'b0;
    idle();

    //             sr1  sr2  u1 u2 dst mr ir irs dr drs br   ld        fl      st    stl
    vt[0]  = '{3'd0,3'd0,1'b0,1'b0,3'd0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,5'b11111,3'b000,2'b00,1'b0};
    vt[1]  = '{3'd3,3'd0,1'b1,1'b0,3'd3,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,5'b00111,3'b010,2'b00,1'b1};
    vt[2]  = '{3'd3,3'd5,1'b0,1'b1,3'd3,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,5'b11111,3'b000,2'b00,1'b0};
    vt[3]  = '{3'd0,3'd5,1'b1,1'b1,3'd5,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,5'b00111,3'b010,2'b00,1'b1};
    vt[4]  = '{3'd0,3'd0,1'b1,1'b0,3'd0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,5'b00111,3'b010,2'b00,1'b1};
    vt[5]  = '{3'd3,3'd0,1'b1,1'b0,3'd3,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,5'b11111,3'b000,2'b00,1'b0};
    vt[6]  = '{3'd0,3'd0,1'b0,1'b0,3'd0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,5'b11111,3'b111,2'b00,1'b0};
    vt[7]  = '{3'd3,3'd0,1'b1,1'b0,3'd3,1'b1,1'b0,1'b0,1'b0,1'b0,1'b1,5'b11111,3'b111,2'b00,1'b0};
    vt[8]  = '{3'd0,3'd0,1'b0,1'b0,3'd0,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,5'b00000,3'b000,2'b10,1'b1};
    vt[9]  = '{3'd3,3'd0,1'b1,1'b0,3'd3,1'b1,1'b1,1'b1,1'b0,1'b0,1'b0,5'b00111,3'b010,2'b00,1'b1};
    vt[10] = '{3'd0,3'd0,1'b0,1'b0,3'd0,1'b0,1'b1,1'b0,1'b1,1'b0,1'b1,5'b00000,3'b000,2'b01,1'b1};
    vt[11] = '{3'd0,3'd0,1'b0,1'b0,3'd0,1'b0,1'b1,1'b0,1'b1,1'b1,1'b0,5'b00000,3'b000,2'b10,1'b1};
    vt[12] = '{3'd0,3'd0,1'b0,1'b0,3'd0,1'b0,1'b1,1'b0,1'b1,1'b0,1'b0,5'b00000,3'b000,2'b01,1'b1};
    vt[13] = '{3'd0,3'd0,1'b0,1'b0,3'd0,1'b0,1'b0,1'b0,1'b1,1'b1,1'b0,5'b11111,3'b000,2'b00,1'b0};

    // Reset state, observed while reset_n is still low.
    #2;
    chk("reset_loads", int'(w_ld), 0);
    chk("reset_flush", int'(w_fl), 0);
    chk("reset_state", int'(state), 0);
    chk("reset_stall_cnt", int'(stall_cycles), 0);
    chk("reset_timeout", int'(mem_timeout), 0);
    do_reset();

    exp_cnt = 0;
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      id_sr1 = vt[i].sr1; id_sr2 = vt[i].sr2;
      id_sr1_used = vt[i].u1; id_sr2_used = vt[i].u2;
      idex_dest = vt[i].dest; idex_mem_read = vt[i].mr;
      imem_req = vt[i].ireq; imem_resp = vt[i].iresp;
      dmem_req = vt[i].dreq; dmem_resp = vt[i].dresp;
      mem_br_taken = vt[i].br;
      #1;
      chk($sformatf("vec%0d_loads", i), int'(w_ld), int'(vt[i].ld));
      chk($sformatf("vec%0d_flush", i), int'(w_fl), int'(vt[i].fl));
      if (vt[i].stl) exp_cnt++;
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d_state", i), int'(state), int'(vt[i].st));
      chk($sformatf("vec%0d_stall_cnt", i), int'(stall_cycles), exp_cnt);
    end

    // D-miss: four frozen cycles, then the response cycle runs.
    do_reset();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      idle(); dmem_req = 1'b1;
      #1;
      chk($sformatf("dmiss%0d_loads", i), int'(w_ld), 0);
      @(posedge clk);
      #1;
      chk($sformatf("dmiss%0d_state", i), int'(state), 1);
    end
    @(negedge clk);
    dmem_resp = 1'b1;
    #1;
    chk("dmiss_resp_loads", int'(w_ld), 5'b11111);
    @(posedge clk);
    #1;
    chk("dmiss_end_state", int'(state), 0);
    chk("dmiss_stall_cnt", int'(stall_cycles), 4);

    // Branch held behind a D-miss acts on the response cycle.
    do_reset();
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      idle(); dmem_req = 1'b1; mem_br_taken = 1'b1;
      #1;
      chk($sformatf("brfrz%0d_flush", i), int'(w_fl), 0);
      chk($sformatf("brfrz%0d_loads", i), int'(w_ld), 0);
      @(posedge clk);
    end
    @(negedge clk);
    dmem_resp = 1'b1;
    #1;
    chk("brresp_flush", int'(w_fl), 3'b111);
    chk("brresp_loads", int'(w_ld), 5'b11111);

    // Watchdog on a long I-miss.
    do_reset();
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      idle(); imem_req = 1'b1;
      @(posedge clk);
      #1;
      if (k == 8) chk("wdog_before", int'(mem_timeout), 0);
      if (k == 9) chk("wdog_set", int'(mem_timeout), 1);
    end
    @(negedge clk);
    imem_resp = 1'b1;
    @(posedge clk);
    #1;
    chk("wdog_sticky", int'(mem_timeout), 1);
    chk("wdog_run", int'(state), 0);

    // Async reset mid-DWAIT, asserted between edges.
    do_reset();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      idle(); dmem_req = 1'b1;
    end
    @(posedge clk);
    @(negedge clk);
    idle();
    #1;
    chk("arst_pre_state", int'(state), 1);
    chk("arst_pre_loads", int'(w_ld), 5'b11111);
    #1;
    reset_n = 1'b0;
    #1;
    chk("arst_state", int'(state), 0);
    chk("arst_stall_cnt", int'(stall_cycles), 0);
    chk("arst_loads", int'(w_ld), 0);
    @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    chk("arst_release_loads", int'(w_ld), 5'b11111);
    @(posedge clk);
    #1;
    chk("arst_release_state", int'(state), 0);

    // Saturation of the narrow stall counter.
    do_reset();
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      idle(); dmem_req = 1'b1;
      @(posedge clk);
    end
    #1;
    chk("sat_stall_cnt", int'(stall_cycles), 15);
    chk("sat_state", int'(state), 1);
    chk("sat_timeout", int'(mem_timeout), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
